// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: routes HPS ioctl bytes to four ROM regions with a per-region
// write/ack handshake, captures mod/DIP bytes and holds the game board in reset while loading.
module rom_load_sequencer #(
    parameter logic [15:0] R0_END      = 16'h8000,
    parameter logic [15:0] R1_END      = 16'hC000,
    parameter logic [15:0] R2_END      = 16'hE000,
    parameter logic [15:0] R3_END      = 16'hF000,
    parameter int          ACK_TIMEOUT = 15,
    parameter int          RESET_HOLD  = 1023
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [3:0]  rom_wr,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    input  logic [3:0]  rom_ack,
    output logic [7:0]  mod_out,
    output logic [63:0] dip_sw,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, HOLD, RUN} state_t;

    state_t            state_q;
    logic [3:0]        rom_wr_q;
    logic [15:0]       rom_addr_q;
    logic [7:0]        rom_data_q;
    logic              wait_q;
    logic [7:0]        mod_q;
    logic [7:0][7:0]   dip_q;
    logic              core_reset_q, load_done_q, load_error_q;
    logic [TW-1:0]     tmo_q;
    logic [HW-1:0]     hold_q;

    logic [15:0] lo;
    logic        in_range, rom_strobe, ack_hit, start;
    logic [3:0]  region_d;
    logic [15:0] offset_d;

    assign lo         = ioctl_addr[15:0];
    assign in_range   = (ioctl_addr[24:16] == 9'd0) && (lo < R3_END);
    assign rom_strobe = (state_q == ACCEPT) && ioctl_download && ioctl_wr &&
                        (ioctl_index == 8'd0) && in_range;
    assign ack_hit    = |(rom_ack & rom_wr_q);
    assign start      = ioctl_download && (ioctl_index == 8'd0);

    always_comb begin
        region_d = 4'b1000;
        offset_d = lo - R2_END;
        if (lo < R0_END) begin
            region_d = 4'b0001;
            offset_d = lo;
        end else if (lo < R1_END) begin
            region_d = 4'b0010;
            offset_d = lo - R0_END;
        end else if (lo < R2_END) begin
            region_d = 4'b0100;
            offset_d = lo - R1_END;
        end
    end

    // The strobe cycle needs an immediate stall; the registered copy covers ISSUE.
    assign ioctl_wait = wait_q | rom_strobe;
    assign rom_wr     = rom_wr_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign mod_out    = mod_q;
    assign dip_sw     = dip_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rom_wr_q     <= 4'd0;
            rom_addr_q   <= 16'd0;
            rom_data_q   <= 8'd0;
            wait_q       <= 1'b0;
            mod_q        <= 8'hFF;
            dip_q        <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            tmo_q        <= '0;
            hold_q       <= '0;
        end else begin
            if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0)
                mod_q <= ioctl_dout;
            if (ioctl_wr && ioctl_index == 8'hFE && ioctl_addr[24:3] == 22'd0)
                dip_q[ioctl_addr[2:0]] <= ioctl_dout;

            // A fresh ROM download may also cut a running reset hold short.
            if (start && (state_q == IDLE || state_q == HOLD || state_q == RUN)) begin
                state_q      <= ACCEPT;
                core_reset_q <= 1'b1;
                load_done_q  <= 1'b0;
                load_error_q <= 1'b0;
            end else begin
                case (state_q)
                    ACCEPT: begin
                        if (rom_strobe) begin
                            rom_wr_q   <= region_d;
                            rom_addr_q <= offset_d;
                            rom_data_q <= ioctl_dout;
                            wait_q     <= 1'b1;
                            tmo_q      <= '0;
                            state_q    <= ISSUE;
                        end else if (!ioctl_download) begin
                            hold_q  <= '0;
                            state_q <= HOLD;
                        end
                    end
                    ISSUE: begin
                        if (ack_hit || tmo_q == TMO_LAST) begin
                            rom_wr_q <= 4'd0;
                            wait_q   <= 1'b0;
                            if (!ack_hit)
                                load_error_q <= 1'b1;
                            hold_q  <= '0;
                            state_q <= ioctl_download ? ACCEPT : HOLD;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (hold_q == HOLD_LAST) begin
                            core_reset_q <= 1'b0;
                            load_done_q  <= 1'b1;
                            state_q      <= RUN;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer: directed and random ROM bytes against a
// region/ack-delay model, reset hold timing, mod/DIP capture and mid-write reset.
module tb_rom_load_sequencer;
    localparam int ACK_TIMEOUT = 15;
    localparam int RESET_HOLD  = 1023;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic        ioctl_wait;
    logic [3:0]  rom_wr, rom_ack;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data, mod_out;
    logic [63:0] dip_sw;
    logic        core_reset, load_done, load_error;

    int   checks = 0;
    int   failures = 0;
    logic exp_err = 1'b0;
    logic [7:0]  exp_mod = 8'hFF;
    logic [63:0] exp_dip = '0;

    rom_load_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .RESET_HOLD(RESET_HOLD)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .rom_wr(rom_wr),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_ack(rom_ack),
        .mod_out(mod_out), .dip_sw(dip_sw), .core_reset(core_reset),
        .load_done(load_done), .load_error(load_error));

    always #10 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = '0; rom_ack = '0;
        step(); step();
        checks++;
        if ({ioctl_wait, rom_wr, rom_addr, rom_data, mod_out, dip_sw, core_reset, load_done, load_error}
            !== {1'b0, 4'd0, 16'd0, 8'd0, 8'hFF, 64'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got wait=%b wr=%h addr=%h data=%h mod=%h dip=%h cr=%b ld=%b le=%b expected 0/0/0/0/ff/0/1/0/0",
                     ioctl_wait, rom_wr, rom_addr, rom_data, mod_out, dip_sw, core_reset, load_done, load_error);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_start();
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        step();
        exp_err = 1'b0;
        checks++;
        if ({core_reset, load_done, load_error, ioctl_wait} !== 4'b1000) begin
            failures++;
            $display("FAIL download_start: got cr/ld/le/wait=%b expected 1000",
                     {core_reset, load_done, load_error, ioctl_wait});
        end
    endtask

    // dly = ISSUE cycles before ack; dly >= ACK_TIMEOUT means the ack never comes.
    task automatic rom_byte(input logic [24:0] a, input logic [7:0] d, input int dly);
        logic        exp_in;
        logic [3:0]  sel;
        logic [15:0] base;
        logic [28:0] exp_v;
        int          n_issue;
        exp_in = (a[24:16] == 9'd0) && (a[15:0] < 16'hF000);
        if (a[15:0] < 16'h8000)      begin sel = 4'b0001; base = 16'h0000; end
        else if (a[15:0] < 16'hC000) begin sel = 4'b0010; base = 16'h8000; end
        else if (a[15:0] < 16'hE000) begin sel = 4'b0100; base = 16'hC000; end
        else                         begin sel = 4'b1000; base = 16'hE000; end
        ioctl_index = 8'd0; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        #1;
        checks++;
        if (ioctl_wait !== exp_in) begin
            failures++;
            $display("FAIL strobe_wait addr=%h: got %b expected %b", a, ioctl_wait, exp_in);
        end
        step();
        ioctl_wr = 1'b0;
        if (exp_in) begin
            n_issue = (dly < ACK_TIMEOUT) ? dly + 1 : ACK_TIMEOUT;
            for (int c = 0; c < n_issue; c++) begin
                rom_ack = 4'($urandom) & ~sel;
                if (c == dly) rom_ack = rom_ack | sel;
                exp_v = {sel, a[15:0] - base, d, 1'b1};
                checks++;
                if ({rom_wr, rom_addr, rom_data, ioctl_wait} !== exp_v) begin
                    failures++;
                    $display("FAIL issue addr=%h cyc=%0d: got wr=%b addr=%h data=%h wait=%b expected %h",
                             a, c, rom_wr, rom_addr, rom_data, ioctl_wait, exp_v);
                end
                step();
            end
            rom_ack = 4'd0;
            if (dly >= ACK_TIMEOUT) exp_err = 1'b1;
        end
        checks++;
        if ({rom_wr, ioctl_wait, load_error} !== {4'd0, 1'b0, exp_err}) begin
            failures++;
            $display("FAIL after_byte addr=%h: got wr=%b wait=%b err=%b expected 0/0/%b",
                     a, rom_wr, ioctl_wait, load_error, exp_err);
        end
    endtask

    task automatic test_directed();
        rom_byte(25'h0000000, 8'hA5, 0);
        rom_byte(25'h0008003, 8'h3C, 3);
        rom_byte(25'h000D000, 8'h77, 99);
        rom_byte(25'h000F000, 8'h11, 0);
        rom_byte(25'h0010000, 8'h22, 0);
        rom_byte(25'h0008000, 8'h5E, 0);
        rom_byte(25'h000EFFF, 8'hC3, 1);
        rom_byte(25'h000BFFF, 8'h99, ACK_TIMEOUT - 1);
    endtask

    task automatic test_random();
        logic [24:0] a;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) a = {9'($urandom_range(1, 511)), 16'($urandom)};
            else                           a = {9'd0, 16'($urandom)};
            rom_byte(a, 8'($urandom), int'($urandom_range(0, ACK_TIMEOUT + 2)));
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        ioctl_download = 1'b0;
        for (int k = 0; k < RESET_HOLD; k++) begin
            step();
            if (core_reset !== 1'b1 || load_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_window: got %0d cycles without reset expected 0", bad);
        end
        step();
        checks++;
        if ({core_reset, load_done, load_error} !== {1'b0, 1'b1, exp_err}) begin
            failures++;
            $display("FAIL hold_release: got cr/ld/le=%b expected 01%b",
                     {core_reset, load_done, load_error}, exp_err);
        end
    endtask

    task automatic aux_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_download = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        if (idx == 8'd1 && a == 25'd0) exp_mod = d;
        if (idx == 8'hFE && a[24:3] == 22'd0) exp_dip[8*a[2:0] +: 8] = d;
        #1;
        checks++;
        if (ioctl_wait !== 1'b0) begin
            failures++;
            $display("FAIL aux_wait idx=%h: got %b expected 0", idx, ioctl_wait);
        end
        step();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step();
    endtask

    task automatic test_aux();
        aux_write(8'd1, 25'd0, 8'h02);
        aux_write(8'd1, 25'd5, 8'h33);
        aux_write(8'hFE, 25'd2, 8'h5A);
        aux_write(8'hFE, 25'd8, 8'hFF);
        for (int i = 0; i < 6; i++)
            aux_write(8'hFE, 25'($urandom_range(0, 9)), 8'($urandom));
        checks++;
        if (mod_out !== exp_mod) begin
            failures++;
            $display("FAIL mod_out: got %h expected %h", mod_out, exp_mod);
        end
        checks++;
        if (dip_sw !== exp_dip) begin
            failures++;
            $display("FAIL dip_sw: got %h expected %h", dip_sw, exp_dip);
        end
        checks++;
        if ({core_reset, load_done, rom_wr} !== {1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL aux_state: got cr=%b ld=%b wr=%b expected 0 1 0000", core_reset, load_done, rom_wr);
        end
    endtask

    task automatic test_drop_in_issue();
        int bad = 0;
        test_start();
        ioctl_addr = 25'h0000100; ioctl_dout = 8'h4D; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step();
        checks++;
        if ({rom_wr, rom_addr, ioctl_wait} !== {4'b0001, 16'h0100, 1'b1}) begin
            failures++;
            $display("FAIL drop_issue_hold: got wr=%b addr=%h wait=%b expected 0001 0100 1", rom_wr, rom_addr, ioctl_wait);
        end
        rom_ack = 4'b0001;
        step();
        rom_ack = 4'd0;
        checks++;
        if ({rom_wr, ioctl_wait, core_reset, load_done, load_error} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL drop_issue_done: got wr=%b wait=%b cr=%b ld=%b le=%b expected 0 0 1 0 0",
                     rom_wr, ioctl_wait, core_reset, load_done, load_error);
        end
        for (int k = 0; k < RESET_HOLD - 1; k++) begin
            step();
            if (core_reset !== 1'b1) bad++;
        end
        step();
        checks++;
        if (bad != 0 || {core_reset, load_done} !== 2'b01) begin
            failures++;
            $display("FAIL drop_issue_release: got bad=%0d cr=%b ld=%b expected 0 0 1", bad, core_reset, load_done);
        end
    endtask

    task automatic test_reset_mid_issue();
        test_start();
        ioctl_addr = 25'h000C010; ioctl_dout = 8'hE1; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        step(); step();
        checks++;
        if (rom_wr !== 4'b0100) begin
            failures++;
            $display("FAIL pre_reset_issue: got %b expected 0100", rom_wr);
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({rom_wr, ioctl_wait, core_reset, load_done, mod_out, dip_sw}
            !== {4'd0, 1'b0, 1'b1, 1'b0, 8'hFF, 64'd0}) begin
            failures++;
            $display("FAIL reset_mid_issue: got wr=%b wait=%b cr=%b ld=%b mod=%h dip=%h expected 0 0 1 0 ff 0",
                     rom_wr, ioctl_wait, core_reset, load_done, mod_out, dip_sw);
        end
        ioctl_download = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_start();
        test_directed();
        test_random();
        test_hold();
        test_aux();
        test_drop_in_issue();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
